// File: rtl/crossing_pkg.sv
// Shared types and constants for the pedestrian crossing phase timer.
package crossing_pkg;

   typedef enum logic [1:0] {
      WAIT_TR = 2'd0,
      RUN     = 2'd1,
      HOLD    = 2'd2
   } phase_state_t;

   localparam logic [1:0] MULT_HOLD = 2'd0;
   localparam logic [1:0] MULT_MAX  = 2'd3;

   // Wide enough to hold the largest target (MULT_MAX * base_ticks) untruncated.
   function automatic int tick_cnt_width(input int base_ticks);
      return $clog2(int'(MULT_MAX) * base_ticks + 1);
   endfunction

endpackage

// File: rtl/crossing_phase_timer_tick_prescaler.sv
// Divides clk into one-cycle ticks every TICK_DIV cycles while enabled.
module tick_prescaler #(
   parameter int TICK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] cnt;

   // A clear on the same edge restarts the phase, so no tick leaks out.
   assign tick = enable && !clear && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (reset || clear)
         cnt <= '0;
      else if (enable)
         cnt <= tick ? '0 : cnt + PW'(1);
   end

endmodule

// File: rtl/crossing_phase_timer.sv
// Phase timer and request latch sequencing the crossing control unit:
// timed RUN phases, and HOLD phases released by a latched pedestrian call.
module crossing_phase_timer
   import crossing_pkg::*;
#(
   parameter int TICK_DIV   = 4,
   parameter int BASE_TICKS = 5,
   parameter int MIN_TICKS  = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tr,
   input  logic [1:0] multiplier,
   input  logic       request,
   output logic       proceed,
   output logic       request_pending,
   output logic       busy
);

   localparam int CW = tick_cnt_width(BASE_TICKS);
   localparam logic [CW-1:0] MIN_CNT = CW'(MIN_TICKS);

   phase_state_t  state, state_nxt;
   logic [CW-1:0] tick_cnt, target;
   logic          tick, run_done, hold_done, proceed_nxt, hold_fire;

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .clk    (clk),
      .reset  (reset),
      .clear  (tr),
      .enable (busy),
      .tick   (tick)
   );

   assign run_done  = tick && (tick_cnt + CW'(1) == target);
   // The minimum counts as met on the very tick that reaches it.
   assign hold_done = request_pending &&
                      ((tick_cnt == MIN_CNT) || (tick && (tick_cnt + CW'(1) == MIN_CNT)));

   always_ff @(posedge clk) begin
      if (reset)
         state <= WAIT_TR;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (tr)
         state_nxt = (multiplier != MULT_HOLD) ? RUN : HOLD;
      else begin
         case (state)
            RUN:     if (run_done)  state_nxt = WAIT_TR;
            HOLD:    if (hold_done) state_nxt = WAIT_TR;
            default: state_nxt = state;
         endcase
      end
   end

   always_comb begin
      busy        = (state != WAIT_TR);
      hold_fire   = !tr && (state == HOLD) && hold_done;
      proceed_nxt = hold_fire || (!tr && (state == RUN) && run_done);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         proceed  <= 1'b0;
         tick_cnt <= '0;
         target   <= '0;
      end else begin
         proceed <= proceed_nxt;
         if (tr) begin
            tick_cnt <= '0;
            target   <= CW'(multiplier) * CW'(BASE_TICKS);
         end else if (tick) begin
            if (state == RUN || tick_cnt != MIN_CNT)
               tick_cnt <= tick_cnt + CW'(1);
         end
      end
   end

   // A new call on the clearing edge wins over the clear.
   always_ff @(posedge clk) begin
      if (reset)
         request_pending <= 1'b0;
      else if (request)
         request_pending <= 1'b1;
      else if (hold_fire)
         request_pending <= 1'b0;
   end

endmodule

// File: tb/tb_crossing_phase_timer.sv
// Randomised and directed bench for crossing_phase_timer against a cycle-time model.
module tb_crossing_phase_timer;

   localparam int TICK_DIV   = 4;
   localparam int BASE_TICKS = 5;
   localparam int MIN_TICKS  = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tr = 1'b0;
   logic [1:0] multiplier = 2'd0;
   logic       request = 1'b0;
   logic       proceed, request_pending, busy;

   int n_chk = 0;
   int n_fail = 0;

   // reference model: elapsed cycles since the restart edge
   bit m_act, m_hold, m_pend, m_proc;
   int m_el, m_mult;

   crossing_phase_timer #(
      .TICK_DIV(TICK_DIV), .BASE_TICKS(BASE_TICKS), .MIN_TICKS(MIN_TICKS)
   ) dut (
      .clk(clk), .reset(reset), .tr(tr), .multiplier(multiplier),
      .request(request), .proceed(proceed),
      .request_pending(request_pending), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step(input bit t, input int m, input bit rq, input bit rs);
      bit pend_n;
      if (rs) begin
         m_act = 0; m_hold = 0; m_pend = 0; m_proc = 0; m_el = 0; m_mult = 0;
         return;
      end
      m_proc = 0;
      pend_n = m_pend | rq;
      if (t) begin
         m_act = 1; m_hold = (m == 0); m_mult = m; m_el = 0;
      end else if (m_act) begin
         m_el++;
         if (!m_hold && m_el == m_mult * BASE_TICKS * TICK_DIV) begin
            m_proc = 1; m_act = 0;
         end else if (m_hold && m_el >= MIN_TICKS * TICK_DIV && m_pend) begin
            m_proc = 1; m_act = 0; pend_n = rq;
         end
      end
      m_pend = pend_n;
   endtask

   task automatic cyc(input bit t, input logic [1:0] m, input bit rq, input bit rs);
      tr = t; multiplier = m; request = rq; reset = rs;
      @(posedge clk);
      model_step(t, int'(m), rq, rs);
      #1;
      check("proceed", int'(proceed), int'(m_proc));
      check("request_pending", int'(request_pending), int'(m_pend));
      check("busy", int'(busy), int'(m_act));
   endtask

   // idle cycles until proceed; at = edges after the call, or -1 on timeout
   task automatic measure(input int max, output int at);
      at = -1;
      for (int i = 1; i <= max; i++) begin
         cyc(1'b0, 2'd0, 1'b0, 1'b0);
         if (proceed === 1'b1) begin
            at = i;
            break;
         end
      end
   endtask

   initial begin
      int at, ph;
      bit pp, t, rq, rs;
      logic [1:0] m;
      logic [1:0] seq [3] = '{2'd3, 2'd1, 2'd0};
      int idx;

      cyc(0, 0, 0, 1);
      cyc(0, 0, 1, 1);
      check("rst_proceed", int'(proceed), 0);
      check("rst_pending", int'(request_pending), 0);
      check("rst_busy", int'(busy), 0);
      cyc(0, 0, 0, 0);

      // RUN lengths
      cyc(1, 1, 0, 0);
      measure(100, at);
      check("run_m1_cycles", at, 20);
      cyc(1, 3, 0, 0);
      measure(100, at);
      check("run_m3_cycles", at, 60);

      // restart mid-phase
      cyc(1, 3, 0, 0);
      measure(29, at);
      check("restart_no_early", at, -1);
      cyc(1, 1, 0, 0);
      measure(100, at);
      check("restart_new_expiry", at, 20);
      cyc(1, 3, 0, 0);
      measure(29, at);
      cyc(1, 3, 0, 0);
      measure(100, at);
      check("restart_m3_expiry", at, 60);

      // unrequested hold persists, then a late request releases it
      cyc(1, 0, 0, 0);
      measure(100, at);
      check("hold_no_proceed", at, -1);
      check("hold_busy", int'(busy), 1);
      cyc(0, 0, 1, 0);
      check("late_req_pending", int'(request_pending), 1);
      check("late_req_no_proceed", int'(proceed), 0);
      cyc(0, 0, 0, 0);
      check("late_req_proceed", int'(proceed), 1);
      check("late_req_cleared", int'(request_pending), 0);
      cyc(0, 0, 0, 0);
      check("proceed_one_wide", int'(proceed), 0);

      // request during RUN releases the next hold at the minimum
      cyc(1, 1, 0, 0);
      cyc(0, 0, 1, 0);
      measure(100, at);
      cyc(1, 0, 0, 0);
      measure(40, at);
      check("hold_min_cycles", at, 12);
      cyc(1, 0, 1, 0);
      for (int i = 0; i < 11; i++) cyc(0, 0, 0, 0);
      cyc(0, 0, 1, 0);
      check("clear_edge_proceed", int'(proceed), 1);
      check("clear_edge_set_wins", int'(request_pending), 1);

      // reset mid-RUN with a pending call
      cyc(1, 3, 1, 0);
      for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 1);
      check("midrst_proceed", int'(proceed), 0);
      check("midrst_pending", int'(request_pending), 0);
      check("midrst_busy", int'(busy), 0);
      measure(80, at);
      check("midrst_no_proceed", at, -1);

      // closed loop with a green/orange/red control unit
      cyc(1, seq[0], 0, 0);
      idx = 1; ph = 0; pp = 0;
      for (int i = 0; i < 3000 && ph < 9; i++) begin
         rq = ($urandom_range(0, 19) == 0);
         if (pp) begin
            cyc(1, seq[idx], rq, 0);
            idx = (idx + 1) % 3;
            ph++;
         end else
            cyc(0, 0, rq, 0);
         pp = (proceed === 1'b1);
      end
      check("loop_phases", ph, 9);

      // random traffic, mostly closed loop with stray restarts and resets
      pp = 0;
      for (int i = 0; i < 4000; i++) begin
         t  = pp || ($urandom_range(0, 59) == 0);
         m  = 2'($urandom_range(0, 3));
         rq = ($urandom_range(0, 24) == 0);
         rs = ($urandom_range(0, 499) == 0);
         cyc(t, m, rq, rs);
         pp = (proceed === 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
